// File: rtl/decode_stage_hs_pkg.sv
// rtl/decode_stage_hs_pkg.sv - opcode/funct values, ctrl bit positions and FSM states for the ID stage
package decode_stage_hs_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes handled in ID
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // o_ctrl bit positions: {regDst,mem2Reg,memRead,memWrite,regWrite,imm,sign,aluSrc,aluOp,width,3'b0}
   localparam int CTRL_REGDST   = 15;
   localparam int CTRL_MEM2REG  = 14;
   localparam int CTRL_MEMREAD  = 13;
   localparam int CTRL_MEMWRITE = 12;
   localparam int CTRL_REGWRITE = 11;
   localparam int CTRL_IMM      = 10;
   localparam int CTRL_SIGN     = 9;
   localparam int CTRL_ALUSRC   = 7;
   localparam int CTRL_ALUOP    = 5;
   localparam int CTRL_WIDTH    = 3;

   localparam logic [1:0] ALUSRC_REG  = 2'b00;
   localparam logic [1:0] ALUSRC_IMM  = 2'b01;
   localparam logic [1:0] ALUSRC_LINK = 2'b10;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;
   localparam logic [1:0] WIDTH_BYTE  = 2'b00;
   localparam logic [1:0] WIDTH_HALF  = 2'b01;
   localparam logic [1:0] WIDTH_WORD  = 2'b11;

   typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

   // JR and JALR both redirect to the rs register value
   function automatic logic is_jr(input logic [5:0] opcode, input logic [5:0] func);
      return (opcode == OP_RTYPE) && ((func == FN_JR) || (func == FN_JALR));
   endfunction

endpackage

// File: rtl/decode_stage_hs_branch_resolver.sv
// rtl/decode_stage_hs_branch_resolver.sv - branch comparator and redirect target mux
module decode_stage_hs_branch_resolver
   import decode_stage_hs_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [5:0]         opcode,
   input  logic [5:0]         func,
   input  logic [25:0]        idx26,
   input  logic [NB_DATA-1:0] pc4,
   input  logic [NB_DATA-1:0] cmp_a,
   input  logic [NB_DATA-1:0] cmp_b,
   output logic               taken,
   output logic [NB_DATA-1:0] target
);

   logic [NB_DATA-1:0] br_off;

   assign br_off = {{(NB_DATA-18){idx26[15]}}, idx26[15:0], 2'b00};

   // Select taken/target by instruction class; non-control instructions never redirect
   always_comb begin
      taken  = 1'b0;
      target = pc4 + br_off;
      case (opcode)
         OP_BEQ: taken = (cmp_a == cmp_b);
         OP_BNE: taken = (cmp_a != cmp_b);
         OP_J, OP_JAL: begin
            taken  = 1'b1;
            target = {pc4[NB_DATA-1 -: 4], idx26, 2'b00};
         end
         default: begin
            if (is_jr(opcode, func)) begin
               taken  = 1'b1;
               target = cmp_a;
            end
         end
      endcase
   end

endmodule

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - MIPS ID stage with valid/ready handshakes; optional BRANCH_FWD_EN adds EX/MEM branch forwarding
module decode_stage_hs
   import decode_stage_hs_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_ADDR  = 5,
   parameter int LINK_REG = 31
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [NB_DATA-1:0] i_instruction,
   input  logic [NB_DATA-1:0] i_pcounter4,
   output logic [NB_ADDR-1:0] o_rs_addr,
   output logic [NB_ADDR-1:0] o_rt_addr,
   input  logic [NB_DATA-1:0] i_rs_data,
   input  logic [NB_DATA-1:0] i_rt_data,
`ifdef BRANCH_FWD_EN
   input  logic               i_exmem_regwrite,
   input  logic [NB_ADDR-1:0] i_exmem_rd,
   input  logic [NB_DATA-1:0] i_exmem_data,
`endif
   input  logic               i_flush,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_DATA-1:0] o_reg_DA,
   output logic [NB_DATA-1:0] o_reg_DB,
   output logic [NB_DATA-1:0] o_immediate,
   output logic [NB_ADDR-1:0] o_rs,
   output logic [NB_ADDR-1:0] o_rt,
   output logic [NB_ADDR-1:0] o_rd,
   output logic [5:0]         o_opcode,
   output logic [5:0]         o_func,
   output logic [4:0]         o_shamt,
   output logic [15:0]        o_ctrl,
   output logic               o_jump,
   output logic [NB_DATA-1:0] o_addr2jump,
   output logic               o_flush_if
);

   state_t             state;
   logic [5:0]         opcode, func;
   logic [NB_ADDR-1:0] rs, rt, rd, idex_dst;
   logic [15:0]        imm16, ctrl;
   logic [NB_DATA-1:0] rs_val, rt_val, cmp_a, cmp_b, imm_ext, br_target;
   logic               zero_ext, is_link, uses_rs_br, uses_rt_br;
   logic               load_use, br_hazard, hazard, accept, br_taken;

   assign opcode    = i_instruction[31:26];
   assign rs        = i_instruction[25:21];
   assign rt        = i_instruction[20:16];
   assign rd        = i_instruction[15:11];
   assign func      = i_instruction[5:0];
   assign imm16     = i_instruction[15:0];
   assign o_rs_addr = rs;
   assign o_rt_addr = rt;

   // $0 is hardwired to zero whatever the register file returns
   assign rs_val = (rs == '0) ? '0 : i_rs_data;
   assign rt_val = (rt == '0) ? '0 : i_rt_data;

   assign is_link    = (opcode == OP_JAL) || ((opcode == OP_RTYPE) && (func == FN_JALR));
   assign uses_rt_br = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign uses_rs_br = uses_rt_br || is_jr(opcode, func);

`ifdef BRANCH_FWD_EN
   assign cmp_a = (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == rs)) ? i_exmem_data : rs_val;
   assign cmp_b = (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == rt)) ? i_exmem_data : rt_val;
`else
   assign cmp_a = rs_val;
   assign cmp_b = rt_val;
`endif

   // Load-use: the load in ID/EX writes rt; a branch reading any register written from ID/EX also waits
   assign idex_dst  = o_ctrl[CTRL_REGDST] ? o_rd : o_rt;
   assign load_use  = o_valid && o_ctrl[CTRL_MEMREAD] && (o_rt != '0) && ((o_rt == rs) || (o_rt == rt));
   assign br_hazard = o_valid && o_ctrl[CTRL_REGWRITE] && (idex_dst != '0) &&
                      ((uses_rs_br && (idex_dst == rs)) || (uses_rt_br && (idex_dst == rt)));
   assign hazard    = load_use || br_hazard;

   assign o_ready = (state == ST_RUN) && (!o_valid || i_ready) && !hazard;
   assign accept  = i_valid && o_ready && !i_flush;

   decode_stage_hs_branch_resolver #(.NB_DATA(NB_DATA)) u_branch_resolver (
      .opcode (opcode),
      .func   (func),
      .idx26  (i_instruction[25:0]),
      .pc4    (i_pcounter4),
      .cmp_a  (cmp_a),
      .cmp_b  (cmp_b),
      .taken  (br_taken),
      .target (br_target)
   );

   assign o_jump      = accept && br_taken;
   assign o_addr2jump = br_target;
   assign o_flush_if  = o_jump;

   assign imm_ext = zero_ext ? {{(NB_DATA-16){1'b0}}, imm16} : {{(NB_DATA-16){imm16[15]}}, imm16};

   // Control word decode; branches, plain jumps and unknown opcodes leave ctrl all-zero
   always_comb begin
      ctrl     = '0;
      zero_ext = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (func == FN_JALR) begin
               ctrl[CTRL_REGDST]          = 1'b1;
               ctrl[CTRL_REGWRITE]        = 1'b1;
               ctrl[CTRL_ALUSRC +: 2]     = ALUSRC_LINK;
            end else if (func != FN_JR) begin
               ctrl[CTRL_REGDST]          = 1'b1;
               ctrl[CTRL_REGWRITE]        = 1'b1;
               ctrl[CTRL_SIGN]            = 1'b1;
               ctrl[CTRL_ALUSRC +: 2]     = ALUSRC_REG;
               ctrl[CTRL_ALUOP +: 2]      = ALUOP_RTYPE;
            end
         end
         OP_JAL: begin
            ctrl[CTRL_REGDST]             = 1'b1;
            ctrl[CTRL_REGWRITE]           = 1'b1;
            ctrl[CTRL_ALUSRC +: 2]        = ALUSRC_LINK;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI,
         OP_ANDI, OP_ORI, OP_XORI: begin
            zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            ctrl[CTRL_REGWRITE]           = 1'b1;
            ctrl[CTRL_IMM]                = 1'b1;
            ctrl[CTRL_SIGN]               = !zero_ext;
            ctrl[CTRL_ALUSRC +: 2]        = ALUSRC_IMM;
            ctrl[CTRL_ALUOP +: 2]         = ALUOP_IMM;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            ctrl[CTRL_MEM2REG]            = 1'b1;
            ctrl[CTRL_MEMREAD]            = 1'b1;
            ctrl[CTRL_REGWRITE]           = 1'b1;
            ctrl[CTRL_IMM]                = 1'b1;
            ctrl[CTRL_SIGN]               = (opcode != OP_LBU) && (opcode != OP_LHU);
            ctrl[CTRL_ALUSRC +: 2]        = ALUSRC_IMM;
            ctrl[CTRL_ALUOP +: 2]         = ALUOP_ADD;
            ctrl[CTRL_WIDTH +: 2]         = (opcode == OP_LW) ? WIDTH_WORD :
                                            ((opcode == OP_LH) || (opcode == OP_LHU)) ? WIDTH_HALF : WIDTH_BYTE;
         end
         OP_SB, OP_SH, OP_SW: begin
            ctrl[CTRL_MEMWRITE]           = 1'b1;
            ctrl[CTRL_IMM]                = 1'b1;
            ctrl[CTRL_SIGN]               = 1'b1;
            ctrl[CTRL_ALUSRC +: 2]        = ALUSRC_IMM;
            ctrl[CTRL_ALUOP +: 2]         = ALUOP_ADD;
            ctrl[CTRL_WIDTH +: 2]         = (opcode == OP_SW) ? WIDTH_WORD :
                                            (opcode == OP_SH) ? WIDTH_HALF : WIDTH_BYTE;
         end
         default: ctrl = '0;
      endcase
   end

   // FSM and ID/EX register: flush beats hazard and accept; a stalled execute holds every field
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= ST_RUN;
         o_valid     <= 1'b0;
         o_ctrl      <= '0;
         o_reg_DA    <= '0;
         o_reg_DB    <= '0;
         o_immediate <= '0;
         o_rs        <= '0;
         o_rt        <= '0;
         o_rd        <= '0;
         o_opcode    <= '0;
         o_func      <= '0;
         o_shamt     <= '0;
      end else if (i_flush) begin
         state   <= ST_RUN;
         o_valid <= 1'b0;
         o_ctrl  <= '0;
      end else begin
         if (state == ST_STALL)
            state <= ST_RUN;
         else if (i_valid && hazard)
            state <= ST_STALL;

         if (!o_valid || i_ready) begin
            if (accept) begin
               o_valid     <= 1'b1;
               o_ctrl      <= ctrl;
               o_reg_DA    <= is_link ? i_pcounter4 : rs_val;
               o_reg_DB    <= is_link ? NB_DATA'(4) : rt_val;
               o_immediate <= imm_ext;
               o_rs        <= rs;
               o_rt        <= rt;
               o_rd        <= (opcode == OP_JAL) ? NB_ADDR'(LINK_REG) : rd;
               o_opcode    <= opcode;
               o_func      <= func;
               o_shamt     <= i_instruction[10:6];
            end else begin
               o_valid <= 1'b0;
               o_ctrl  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb/tb_decode_stage_hs.sv - directed self-checking bench for decode_stage_hs
module tb_decode_stage_hs;

   logic        clk = 1'b0;
   logic        i_rst, i_valid, i_flush, i_ready;
   logic [31:0] i_instruction, i_pcounter4, i_rs_data, i_rt_data;
   logic [4:0]  o_rs_addr, o_rt_addr, o_rs, o_rt, o_rd;
   logic        o_ready, o_valid, o_jump, o_flush_if;
   logic [31:0] o_reg_DA, o_reg_DB, o_immediate, o_addr2jump;
   logic [5:0]  o_opcode, o_func;
   logic [4:0]  o_shamt;
   logic [15:0] o_ctrl;
`ifdef BRANCH_FWD_EN
   logic        i_exmem_regwrite;
   logic [4:0]  i_exmem_rd;
   logic [31:0] i_exmem_data;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_stage_hs dut (
      .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_instruction(i_instruction), .i_pcounter4(i_pcounter4),
      .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
`ifdef BRANCH_FWD_EN
      .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
`endif
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_reg_DA(o_reg_DA), .o_reg_DB(o_reg_DB), .o_immediate(o_immediate),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_opcode(o_opcode), .o_func(o_func),
      .o_shamt(o_shamt), .o_ctrl(o_ctrl), .o_jump(o_jump), .o_addr2jump(o_addr2jump),
      .o_flush_if(o_flush_if)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic half;
      @(negedge clk);
   endtask

   task automatic drain;
      i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
      cyc; cyc;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
      i_instruction = 32'h0; i_pcounter4 = 32'h0; i_rs_data = 32'h0; i_rt_data = 32'h0;
      cyc; cyc;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", o_valid); end
      checks++; if (o_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", o_ctrl); end
      checks++; if (o_reg_DA !== 32'h0) begin errors++; $display("FAIL reset_DA got %h exp 0", o_reg_DA); end
      checks++; if (o_rd !== 5'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", o_rd); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %h exp 1", o_ready); end
      i_rst = 1'b0;
      cyc;
   endtask

   task automatic test_alu;
      drain;
      i_valid = 1'b1; i_instruction = 32'h00221821; i_pcounter4 = 32'h40; i_rs_data = 32'd5; i_rt_data = 32'd7;
      half;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %h exp 1", o_ready); end
      checks++; if (o_rs_addr !== 5'd1 || o_rt_addr !== 5'd2) begin errors++; $display("FAIL alu_raddr got %0d/%0d exp 1/2", o_rs_addr, o_rt_addr); end
      cyc;
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %h exp 1", o_valid); end
      checks++; if (o_reg_DA !== 32'd5 || o_reg_DB !== 32'd7) begin errors++; $display("FAIL alu_operands got %h/%h exp 5/7", o_reg_DA, o_reg_DB); end
      checks++; if (o_ctrl[11] !== 1'b1 || o_ctrl[15] !== 1'b1) begin errors++; $display("FAIL alu_ctrl got %h exp regWrite,regDst set", o_ctrl); end
      checks++; if (o_rd !== 5'd3 || o_func !== 6'h21) begin errors++; $display("FAIL alu_fields got rd %0d func %h exp 3/21", o_rd, o_func); end
   endtask

   task automatic test_load_use;
      drain;
      i_valid = 1'b1; i_instruction = 32'h8C240000; i_rs_data = 32'h1000; i_rt_data = 32'h0;
      cyc;
      checks++; if (o_ctrl[13] !== 1'b1) begin errors++; $display("FAIL lu_memread got %h exp 1", o_ctrl[13]); end
      i_instruction = 32'h00842820; i_rs_data = 32'h11; i_rt_data = 32'h11;
      half;
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_hazard got %h exp 0", o_ready); end
      cyc;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", o_valid); end
      half;
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_stall got %h exp 0", o_ready); end
      cyc;
      half;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_resume got %h exp 1", o_ready); end
      cyc;
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_rd !== 5'd5 || o_reg_DA !== 32'h11) begin errors++; $display("FAIL lu_add_enters got v%h rd%0d DA%h exp v1 rd5 DA11", o_valid, o_rd, o_reg_DA); end
   endtask

   task automatic test_branch;
      drain;
      i_valid = 1'b1; i_instruction = 32'h10220003; i_pcounter4 = 32'h100; i_rs_data = 32'h55; i_rt_data = 32'h55;
      half;
      checks++; if (o_jump !== 1'b1 || o_flush_if !== 1'b1) begin errors++; $display("FAIL beq_taken got %h/%h exp 1/1", o_jump, o_flush_if); end
      checks++; if (o_addr2jump !== 32'h10C) begin errors++; $display("FAIL beq_target got %h exp 10c", o_addr2jump); end
      cyc;
      i_valid = 1'b0;
      half;
      checks++; if (o_jump !== 1'b0 || o_flush_if !== 1'b0) begin errors++; $display("FAIL beq_one_cycle got %h/%h exp 0/0", o_jump, o_flush_if); end
      cyc;
      i_valid = 1'b1; i_rt_data = 32'h56;
      half;
      checks++; if (o_jump !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %h exp 0", o_jump); end
      cyc;
      i_instruction = 32'h00200008; i_rs_data = 32'h2000;
      half;
      checks++; if (o_jump !== 1'b1 || o_addr2jump !== 32'h2000) begin errors++; $display("FAIL jr got %h %h exp 1 2000", o_jump, o_addr2jump); end
      cyc;
      i_valid = 1'b0;
   endtask

   task automatic test_jal;
      drain;
      i_valid = 1'b1; i_instruction = 32'h0C000040; i_pcounter4 = 32'h10000008;
      half;
      checks++; if (o_jump !== 1'b1 || o_addr2jump !== 32'h10000100) begin errors++; $display("FAIL jal_target got %h %h exp 1 10000100", o_jump, o_addr2jump); end
      cyc;
      i_valid = 1'b0;
      checks++; if (o_rd !== 5'd31) begin errors++; $display("FAIL jal_rd got %0d exp 31", o_rd); end
      checks++; if (o_reg_DA !== 32'h10000008 || o_reg_DB !== 32'd4) begin errors++; $display("FAIL jal_operands got %h/%h exp 10000008/4", o_reg_DA, o_reg_DB); end
   endtask

   task automatic test_hold_flush;
      drain;
      i_valid = 1'b1; i_instruction = 32'h00221821; i_rs_data = 32'hA; i_rt_data = 32'hB;
      cyc;
      i_ready = 1'b0; i_instruction = 32'h00223021; i_rs_data = 32'h99;
      for (int k = 0; k < 3; k++) begin
         half;
         checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %h exp 0", k, o_ready); end
         checks++; if (o_valid !== 1'b1 || o_reg_DA !== 32'hA || o_rd !== 5'd3) begin errors++; $display("FAIL hold_stable[%0d] got v%h DA%h rd%0d exp v1 DAa rd3", k, o_valid, o_reg_DA, o_rd); end
         cyc;
      end
      i_flush = 1'b1;
      cyc;
      i_flush = 1'b0; i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hold_flush got %h exp 0", o_valid); end
      i_ready = 1'b1;
   endtask

   task automatic test_flush_and_reset_on_hazard;
      drain;
      i_valid = 1'b1; i_instruction = 32'h8C240000; i_rs_data = 32'h0;
      cyc;
      i_instruction = 32'h00842820; i_flush = 1'b1;
      cyc;
      i_flush = 1'b0; i_valid = 1'b0;
      half;
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_hazard got rdy%h v%h exp 1/0", o_ready, o_valid); end
      cyc;
      i_valid = 1'b1; i_instruction = 32'h8C240000;
      cyc;
      i_instruction = 32'h00842820; i_rst = 1'b1;
      cyc;
      i_rst = 1'b0; i_valid = 1'b0;
      half;
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL reset_vs_hazard got rdy%h v%h exp 1/0", o_ready, o_valid); end
      cyc;
   endtask

   task automatic test_zero_imm_unknown;
      drain;
      i_valid = 1'b1; i_instruction = 32'h00001821; i_rs_data = 32'hDEAD; i_rt_data = 32'hBEEF;
      cyc;
      checks++; if (o_reg_DA !== 32'h0 || o_reg_DB !== 32'h0) begin errors++; $display("FAIL reg0 got %h/%h exp 0/0", o_reg_DA, o_reg_DB); end
      i_instruction = 32'h30418000;
      cyc;
      checks++; if (o_immediate !== 32'h00008000) begin errors++; $display("FAIL andi_zext got %h exp 00008000", o_immediate); end
      i_instruction = 32'h24028000;
      cyc;
      checks++; if (o_immediate !== 32'hFFFF8000) begin errors++; $display("FAIL addiu_sext got %h exp ffff8000", o_immediate); end
      i_instruction = 32'hFC000000;
      cyc;
      checks++; if (o_valid !== 1'b1 || o_ctrl !== 16'h0) begin errors++; $display("FAIL unknown_op got v%h ctrl%h exp 1/0", o_valid, o_ctrl); end
      i_instruction = 32'h8C200000;
      cyc;
      i_instruction = 32'h00002820;
      half;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL load_r0_nostall got %h exp 1", o_ready); end
      cyc;
      i_valid = 1'b0;
   endtask

   task automatic test_branch_source;
      drain;
`ifdef BRANCH_FWD_EN
      i_exmem_regwrite = 1'b1; i_exmem_rd = 5'd2; i_exmem_data = 32'd9;
      i_valid = 1'b1; i_instruction = 32'h14400001; i_pcounter4 = 32'h200; i_rs_data = 32'h0; i_rt_data = 32'h77;
      half;
      checks++; if (o_ready !== 1'b1 || o_jump !== 1'b1) begin errors++; $display("FAIL fwd_bne got rdy%h j%h exp 1/1", o_ready, o_jump); end
      checks++; if (o_addr2jump !== 32'h204) begin errors++; $display("FAIL fwd_bne_target got %h exp 204", o_addr2jump); end
      cyc;
      i_valid = 1'b0; i_exmem_regwrite = 1'b0;
`else
      i_valid = 1'b1; i_instruction = 32'h24020009; i_rs_data = 32'h0; i_rt_data = 32'h0;
      cyc;
      i_instruction = 32'h14400001; i_pcounter4 = 32'h200; i_rs_data = 32'd9; i_rt_data = 32'h77;
      for (int k = 0; k < 2; k++) begin
         half;
         checks++; if (o_ready !== 1'b0 || o_jump !== 1'b0) begin errors++; $display("FAIL bne_stall[%0d] got rdy%h j%h exp 0/0", k, o_ready, o_jump); end
         cyc;
      end
      half;
      checks++; if (o_ready !== 1'b1 || o_jump !== 1'b1) begin errors++; $display("FAIL bne_resume got rdy%h j%h exp 1/1", o_ready, o_jump); end
      checks++; if (o_addr2jump !== 32'h204) begin errors++; $display("FAIL bne_target got %h exp 204", o_addr2jump); end
      cyc;
      i_valid = 1'b0;
`endif
   endtask

   initial begin
`ifdef BRANCH_FWD_EN
      i_exmem_regwrite = 1'b0; i_exmem_rd = 5'd0; i_exmem_data = 32'h0;
`endif
      test_reset;
      test_alu;
      test_load_use;
      test_branch;
      test_jal;
      test_hold_flush;
      test_flush_and_reset_on_hazard;
      test_zero_imm_unknown;
      test_branch_source;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
